// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
//   In-order queue of predicted branches between fetch and execute. Fetch
//   pushes {prediction-table index, predicted direction}; execute resolves
//   the oldest entry with the actual direction. Each resolve produces a
//   registered one-cycle predictor-update strobe. A misprediction, an
//   external flush or a reset discards every younger entry.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   pushValid/pushIndex/
//   pushPredTaken/pushReady  fetch-side push channel
//   resValid/resTaken/
//   resReady                 execute-side resolve channel (pops head)
//   flush                    discard all entries (same-cycle resolve still reported)
//   updValid/wIndex/takenIn  predictor update request (registered)
//   mispredict               strobe: resolved direction differed from prediction
//   count                    current occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. Ready depends only on registered occupancy, never on valid, and
// valid does not wait for ready.

module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pushValid,
    input  logic [IDX_W-1:0]           pushIndex,
    input  logic                       pushPredTaken,
    output logic                       pushReady,
    input  logic                       resValid,
    input  logic                       resTaken,
    output logic                       resReady,
    input  logic                       flush,
    output logic                       updValid,
    output logic [IDX_W-1:0]           wIndex,
    output logic                       takenIn,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]     head;
    logic [PTR_W:0]     tail;
    logic [IDX_W-1:0]   mem_index [DEPTH];
    logic               mem_pred  [DEPTH];

    logic               full;
    logic               empty;
    logic               push_fire;
    logic               res_fire;
    logic               res_miss;
    logic [IDX_W-1:0]   head_index;
    logic               head_pred;

    assign full  = (head[PTR_W] != tail[PTR_W]) &&
                   (head[PTR_W-1:0] == tail[PTR_W-1:0]);
    assign empty = (head == tail);

    assign pushReady = !full;
    assign resReady  = !empty;
    assign count     = tail - head;

    assign head_index = mem_index[head[PTR_W-1:0]];
    assign head_pred  = mem_pred[head[PTR_W-1:0]];

    assign push_fire = pushValid && pushReady;
    assign res_fire  = resValid && resReady;
    assign res_miss  = res_fire && (resTaken != head_pred);

    // Storage needs no reset: empty pointers hide stale contents. A push that
    // is discarded by flush/mispredict is not written either.
    always_ff @(posedge clk) begin
        if (push_fire && !flush && !res_miss) begin
            mem_index[tail[PTR_W-1:0]] <= pushIndex;
            mem_pred[tail[PTR_W-1:0]]  <= pushPredTaken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            updValid   <= 1'b0;
            mispredict <= 1'b0;
            wIndex     <= '0;
            takenIn    <= 1'b0;
        end else begin
            // The resolving branch retired before any flush, so it is always
            // reported; wIndex/takenIn hold between resolves.
            updValid   <= res_fire;
            mispredict <= res_miss;
            if (res_fire) begin
                wIndex  <= head_index;
                takenIn <= resTaken;
            end

            if (flush || res_miss) begin
                // Everything still queued (and any same-cycle push) is younger
                // than the flush point; collapse to empty at the current tail.
                head <= tail;
            end else begin
                if (push_fire) begin
                    tail <= tail + PTR_ONE;
                end
                if (res_fire) begin
                    head <= head + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.

module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n = 1'b0;
    logic               push_valid = 1'b0;
    logic [IDX_W-1:0]   push_index = '0;
    logic               push_pred = 1'b0;
    logic               push_ready;
    logic               res_valid = 1'b0;
    logic               res_taken = 1'b0;
    logic               res_ready;
    logic               flush = 1'b0;
    logic               upd_valid;
    logic [IDX_W-1:0]   w_index;
    logic               taken_in;
    logic               mispredict;
    logic [CNT_W-1:0]   count;

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pushValid     (push_valid),
        .pushIndex     (push_index),
        .pushPredTaken (push_pred),
        .pushReady     (push_ready),
        .resValid      (res_valid),
        .resTaken      (res_taken),
        .resReady      (res_ready),
        .flush         (flush),
        .updValid      (upd_valid),
        .wIndex        (w_index),
        .takenIn       (taken_in),
        .mispredict    (mispredict),
        .count         (count)
    );

    // ---------------- scoreboard / reference model ----------------
    // Each entry is {index, predicted_taken}; front = oldest branch.
    logic [IDX_W:0]     exp_q[$];
    logic               exp_upd = 1'b0;
    logic               exp_mis = 1'b0;
    logic [IDX_W-1:0]   exp_widx = '0;
    logic               exp_taken = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step(input logic r, input logic pv, input logic [IDX_W-1:0] pi,
                              input logic pp, input logic rv, input logic rt, input logic fl);
        logic acc_push, acc_res;
        logic [IDX_W:0] h;
        if (!r) begin
            exp_q.delete();
            exp_upd = 0; exp_mis = 0; exp_widx = '0; exp_taken = 0;
            return;
        end
        acc_push = pv && (exp_q.size() < DEPTH);
        acc_res  = rv && (exp_q.size() > 0);
        exp_upd  = acc_res;
        exp_mis  = 0;
        if (acc_res) begin
            h = exp_q.pop_front();
            exp_widx  = h[IDX_W:1];
            exp_taken = rt;
            exp_mis   = (rt != h[0]);
        end
        if (fl || exp_mis) exp_q.delete();
        else if (acc_push) exp_q.push_back({pi, pp});
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},      32'(count),      32'(exp_q.size()));
        check({tag, ".pushReady"},  32'(push_ready), 32'(exp_q.size() < DEPTH));
        check({tag, ".resReady"},   32'(res_ready),  32'(exp_q.size() > 0));
        check({tag, ".updValid"},   32'(upd_valid),  32'(exp_upd));
        check({tag, ".mispredict"}, 32'(mispredict), 32'(exp_mis));
        check({tag, ".wIndex"},     32'(w_index),    32'(exp_widx));
        check({tag, ".takenIn"},    32'(taken_in),   32'(exp_taken));
    endtask

    // ---------------- driver ----------------
    // Inputs change #1 after a rising edge; outputs are checked there too.
    task automatic step(input string tag, input logic r, input logic pv, input logic [IDX_W-1:0] pi,
                        input logic pp, input logic rv, input logic rt, input logic fl);
        rst_n = r; push_valid = pv; push_index = pi; push_pred = pp;
        res_valid = rv; res_taken = rt; flush = fl;
        model_step(r, pv, pi, pp, rv, rt, fl);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [IDX_W-1:0] pi, input logic pp);
        step(tag, 1, 1, pi, pp, 0, 0, 0);
    endtask

    task automatic resolve(input string tag, input logic rt);
        step(tag, 1, 0, '0, 0, 1, rt, 0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1, 0, '0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [IDX_W:0] hd;
        logic rv, rt;

        step("reset", 0, 0, '0, 0, 0, 0, 0);
        check("reset_pushReady_lit", 32'(push_ready), 32'd1);
        check("reset_resReady_lit",  32'(res_ready),  32'd0);

        // In-order resolves, both correctly predicted.
        push("p37a", 4'd3, 1);
        push("p37b", 4'd7, 0);
        resolve("r37a", 1);
        check("r37a_widx_lit", 32'(w_index), 32'd3);
        resolve("r37b", 0);
        check("r37b_widx_lit", 32'(w_index), 32'd7);
        check("r37b_count_lit", 32'(count), 32'd0);

        // Fill, overflow push, then one resolve.
        for (int i = 0; i < DEPTH; i++) push("fill", IDX_W'(i + 8), 1'(i));
        check("full_pushReady_lit", 32'(push_ready), 32'd0);
        push("overflow", 4'hF, 1);
        resolve("r38", 0);
        check("r38_count_lit", 32'(count), 32'(DEPTH - 1));
        while (exp_q.size() > 0) begin
            hd = exp_q[0];
            resolve("drain", hd[0]);
        end

        // Mispredict at head discards the rest.
        push("p39a", 4'd1, 1);
        push("p39b", 4'd2, 1);
        push("p39c", 4'd5, 0);
        resolve("r39", 0);
        check("r39_mis_lit", 32'(mispredict), 32'd1);
        check("r39_widx_lit", 32'(w_index), 32'd1);
        idle("r39_idle");

        // Resolve on an empty queue.
        for (int i = 0; i < 3; i++) resolve("empty_res", 1);

        // Flush with a same-cycle correct resolve and push.
        push("p41a", 4'd9, 1);
        push("p41b", 4'd4, 0);
        push("p41c", 4'd6, 1);
        push("p41d", 4'd2, 0);
        step("flush_res", 1, 1, 4'd12, 1, 1, 1, 1);
        check("flush_widx_lit", 32'(w_index), 32'd9);
        check("flush_count_lit", 32'(count), 32'd0);

        // Mispredict with a same-cycle push.
        push("pm", 4'd3, 1);
        step("mis_push", 1, 1, 4'd4, 0, 1, 0, 0);

        // Full-throughput push/resolve pairs across several pointer wraps.
        push("wrap_prime", 4'd0, 0);
        for (int i = 1; i <= 20; i++) begin
            hd = exp_q[0];
            step("wrap", 1, 1, IDX_W'(i), 1'(i % 3 == 0), 1, hd[0], 0);
        end
        resolve("wrap_last", 0);

        // Reset mid-operation with a resolve pending.
        for (int i = 0; i < 5; i++) push("pre_rst", IDX_W'(i), 1);
        step("mid_reset", 0, 0, '0, 0, 1, 1, 0);
        check("mid_reset_upd_lit", 32'(upd_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 99) < 55);
            if (exp_q.size() > 0) begin
                hd = exp_q[0];
                rt = ($urandom_range(0, 99) < 15) ? !hd[0] : hd[0];
            end else begin
                rt = 1'($urandom_range(0, 1));
            end
            step("rand",
                 !($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 65),
                 IDX_W'($urandom_range(0, (1 << IDX_W) - 1)),
                 1'($urandom_range(0, 1)),
                 rv, rt,
                 ($urandom_range(0, 99) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
